// File: rtl/counter_mod_step.sv
// rtl/counter_mod_step.sv - up/down modulo counter with run-time limit, step, load and wrap/saturate
// Optional Gray-coded output oGRAY is built only when COUNTER_GRAY_EN is defined.
module counter_mod_step #(
   parameter int MAX_COUNT = 32,
   parameter int W         = $clog2(MAX_COUNT),
   parameter int STEP_W    = 3
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              iENABLE,
   input  logic              iUP_DOWN,
   input  logic              iLOAD,
   input  logic [W-1:0]      iLOAD_VAL,
   input  logic [W-1:0]      iMOD,
   input  logic [STEP_W-1:0] iSTEP,
   input  logic              iSAT,
   output logic [W-1:0]      oCOUNT,
   output logic              oTC,
   output logic              oAT_MAX,
   output logic              oAT_MIN
`ifdef COUNTER_GRAY_EN
   ,
   output logic [W-1:0]      oGRAY
`endif
);

   // Intermediate sums are one bit wider than the wider operand so they never wrap
   localparam int SW = ((W > STEP_W) ? W : STEP_W) + 1;
   localparam logic [W-1:0] MAX_M1 = W'(MAX_COUNT - 1);

   logic [W-1:0]  count_q, count_d;
   logic          tc_q, tc_d;
   logic [W-1:0]  lim;
   logic [SW-1:0] c_ext, s_ext, l_ext, lp1, sum_up;

   // Effective limit L: iMOD clamped to the top of the physical range
   always_comb begin
      lim = (iMOD > MAX_M1) ? MAX_M1 : iMOD;
   end

   // Widened operands for overflow-free comparisons against L
   always_comb begin
      c_ext  = SW'(count_q);
      s_ext  = SW'(iSTEP);
      l_ext  = SW'(lim);
      lp1    = SW'(lim) + SW'(1);
      sum_up = c_ext + s_ext;
   end

   // Next count and terminal-count pulse: load beats enable, enable beats hold
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (iLOAD) begin
         count_d = (iLOAD_VAL > lim) ? lim : iLOAD_VAL;
      end else if (iENABLE && (iSTEP != '0)) begin
         if (count_q > lim) begin
            // Limit shrank below the current count: snap back into range
            count_d = iSAT ? lim : '0;
            tc_d    = 1'b1;
         end else if (iUP_DOWN) begin
            if (sum_up <= l_ext) begin
               count_d = W'(sum_up);
            end else begin
               tc_d = 1'b1;
               if (iSAT)
                  count_d = lim;
               else if (s_ext > lp1)
                  count_d = '0;
               else
                  count_d = W'(sum_up - lp1);
            end
         end else begin
            if (c_ext >= s_ext) begin
               count_d = W'(c_ext - s_ext);
            end else begin
               tc_d = 1'b1;
               if (iSAT)
                  count_d = '0;
               else if (s_ext > lp1)
                  count_d = lim;
               else
                  count_d = W'(c_ext + lp1 - s_ext);
            end
         end
      end
   end

   // Count and terminal-count registers; reset overrides load and enable
   always_ff @(posedge iCLK) begin
      if (!iRST_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

`ifdef COUNTER_GRAY_EN
   logic [W-1:0] gray_q, gray_d;

   // Gray code of the next count so oGRAY lines up with oCOUNT
   always_comb begin
      gray_d = count_d ^ (count_d >> 1);
   end

   // Gray register for clock-domain-crossing pointers
   always_ff @(posedge iCLK) begin
      if (!iRST_n)
         gray_q <= '0;
      else
         gray_q <= gray_d;
   end

   assign oGRAY = gray_q;
`endif

   assign oCOUNT  = count_q;
   assign oTC     = tc_q;
   assign oAT_MAX = (count_q == lim);
   assign oAT_MIN = (count_q == '0);

endmodule
